rr_decoder_arbiter: RTL and testbench

- Four-requester round-robin arbiter that sequences ownership of a shared resource.
- Selects one owner per grant and drives the address0/address1/enable inputs of a 2-to-4 decoder.
- The decoder's one-hot outputs are the grant lines.
- Sits between the requesting units and the decoder; a per-grant hold limit bounds starvation.

---
 rtl/rr_decoder_arbiter_pkg.sv | 35 +++
 rtl/rr_decoder_arbiter_dec.sv | 16 +
 rtl/rr_decoder_arbiter.sv | 117 +++++++++++
 tb/tb_rr_decoder_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared constants, state encoding and the rotating priority search for the
// four-requester round-robin arbiter.
package rr_decoder_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // Scan from last+1 upward with wrap; last itself is visited last, so the
    // current owner only wins when nobody else is asking.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + IDX_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_dec.sv
// Behavioural 2-to-4 decoder; outputs are all low while enable is low.
module rr_decoder_arbiter_dec (
    input  logic       address0,
    input  logic       address1,
    input  logic       enable,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (enable) begin
            y[{address1, address0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sequencing ownership of a shared resource; the grant
// index is registered and decoded into one-hot grant lines.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic             address0,
    output logic             address1,
    output logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               en_q, en_d;
    logic               pre_q, pre_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_d;

    logic [N_REQ-1:0]   owner_mask;
    logic               owner_req;
    logic               others;
    logic [IDX_W-1:0]   win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
            en_q     <= 1'b0;
            pre_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            en_q     <= en_d;
            pre_q    <= pre_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        owner_mask         = '0;
        owner_mask[addr_q] = 1'b1;
        owner_req          = req[addr_q];
        others             = |(req & ~owner_mask);
        win                = rr_pick(req, last_q);

        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        en_d    = en_q;
        pre_d   = 1'b0;
        hold_d  = hold_cnt;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    addr_d  = win;
                    last_d  = win;
                    en_d    = 1'b1;
                    hold_d  = HOLD_ONE;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!owner_req) begin
                    if (others) begin
                        addr_d = win;
                        last_d = win;
                        hold_d = HOLD_ONE;
                    end else begin
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && others) begin
                    // owner is searched last, so win is never the owner here
                    addr_d = win;
                    last_d = win;
                    hold_d = HOLD_ONE;
                    pre_d  = 1'b1;
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_d = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    assign address0 = addr_q[0];
    assign address1 = addr_q[1];
    assign enable   = en_q;
    assign busy     = en_q;
    assign preempt  = pre_q;

    rr_decoder_arbiter_dec u_dec (
        .address0 (address0),
        .address1 (address1),
        .enable   (enable),
        .y        (gnt)
    );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: a per-cycle vector table plus
// hand-written multi-cycle sequences for reset, hold limit and saturation.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       address0;
    logic       address1;
    logic       enable;
    logic [3:0] gnt;
    logic       busy;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    rr_decoder_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .address0 (address0),
        .address1 (address1),
        .enable   (enable),
        .gnt      (gnt),
        .busy     (busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] eg, input logic eb, input logic ep);
        logic [3:0] dec;
        chk({name, ".gnt"}, 32'(gnt), 32'(eg));
        chk({name, ".busy"}, 32'(busy), 32'(eb));
        chk({name, ".enable"}, 32'(enable), 32'(eb));
        chk({name, ".preempt"}, 32'(preempt), 32'(ep));
        chk({name, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
        if (eb) begin
            dec = 4'b0001 << {address1, address0};
            chk({name, ".addr"}, 32'(dec), 32'(eg));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single requester
        vecs[0]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        // round robin with owners dropping after each grant
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b1110, 4'b0010, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b1101, 4'b0100, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b1011, 4'b1000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0111, 4'b0001, 1'b1, 1'b0};
        // release by owner 3 wraps to 0 ahead of 1
        vecs[10] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        // simultaneous requests follow the rotating pointer
        vecs[13] = '{1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'b0110, 4'b0100, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        reset = 1'b1;
        req   = 4'b0000;
        #3;
        chk_out("reset_init", 4'b0000, 1'b0, 1'b0);
        chk("reset_addr", 32'({address1, address0}), 32'd0);
        #4;
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst) begin
                req = vecs[i].req;
                do_reset();
                #1;
            end else begin
                step(vecs[i].req);
            end
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].pre);
        end

        // asynchronous reset in the middle of a grant
        do_reset();
        step(4'b1111);
        step(4'b1110);
        chk_out("pre_async", 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        req   = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_out("first_after_rst", 4'b0001, 1'b1, 1'b0);

        // hold limit with two persistent requesters
        step(4'b0000);
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b0011);
            chk_out($sformatf("hold0_c%0d", c), 4'b0001, 1'b1, 1'b0);
        end
        step(4'b0011);
        chk_out("preempt_to1", 4'b0010, 1'b1, 1'b1);
        for (int c = 0; c < 7; c++) begin
            step(4'b0011);
            chk_out($sformatf("hold1_c%0d", c), 4'b0010, 1'b1, 1'b0);
        end
        step(4'b0011);
        chk_out("preempt_to0", 4'b0001, 1'b1, 1'b1);

        // sole requester is never preempted; counter saturates
        step(4'b0000);
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b1000);
            chk_out($sformatf("sole_c%0d", c), 4'b1000, 1'b1, 1'b0);
        end
        chk("hold_saturate", 32'(u_dut.hold_cnt), 32'd8);
        step(4'b0000);
        chk_out("sole_release", 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
